draw_list_sequencer: RTL

Parametrised successor to the bird/pipe draw multiplexer. Once per frame it snapshots up to NUM_OBJ rectangle descriptors and issues one screen-clear request. It then streams each enabled rectangle, in index order, to the frame-buffer drawer over a valid/ready handshake. It sits between the game-object logic (bird, pipes, score, ground) and the rectangle drawer/memory writer.

---
 rtl/draw_list_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/draw_list_sequencer.sv
// Per-frame draw list sequencer: snapshots NUM_OBJ rectangles, issues a screen clear,
// then streams enabled rectangles in index order. Optional clipping: DRAW_SEQ_CLIP_EN.
module draw_list_sequencer #(
   parameter int N        = 11,
   parameter int NUM_OBJ  = 4,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic [NUM_OBJ-1:0]   obj_en,
   input  logic [NUM_OBJ*N-1:0] obj_x0,
   input  logic [NUM_OBJ*N-1:0] obj_y0,
   input  logic [NUM_OBJ*N-1:0] obj_x1,
   input  logic [NUM_OBJ*N-1:0] obj_y1,
   input  logic                 ready,
   output logic [N-1:0]         x0,
   output logic [N-1:0]         y0,
   output logic [N-1:0]         x1,
   output logic [N-1:0]         y1,
   output logic                 wr,
   output logic                 clearScreen,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overrun
);

   localparam int IW = $clog2(NUM_OBJ + 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_OBJ);

   if (NUM_OBJ < 1 || NUM_OBJ > 16 || SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_cfg
      $error("draw_list_sequencer: invalid parameter set");
   end

   typedef enum logic [2:0] {IDLE, CLEAR, SCAN, EMIT, DONE} state_t;

   state_t             state;
   logic [IW-1:0]      idx;
   logic [NUM_OBJ-1:0] sh_en;
   logic [N-1:0]       sh_x0 [NUM_OBJ];
   logic [N-1:0]       sh_y0 [NUM_OBJ];
   logic [N-1:0]       sh_x1 [NUM_OBJ];
   logic [N-1:0]       sh_y1 [NUM_OBJ];

   logic               cur_en;
   logic [N-1:0]       cur_x0, cur_y0, cur_x1, cur_y1;
   logic [N-1:0]       ld_x0, ld_y0, ld_x1, ld_y1;

   always_ff @(posedge clock) begin
      if (state == IDLE && frame_start) begin
         sh_en <= obj_en;
         for (int unsigned k = 0; k < NUM_OBJ; k++) begin
            sh_x0[k] <= obj_x0[k*N +: N];
            sh_y0[k] <= obj_y0[k*N +: N];
            sh_x1[k] <= obj_x1[k*N +: N];
            sh_y1[k] <= obj_y1[k*N +: N];
         end
      end
   end

   always_comb begin
      cur_en = 1'b0;
      cur_x0 = '0;
      cur_y0 = '0;
      cur_x1 = '0;
      cur_y1 = '0;
      for (int unsigned k = 0; k < NUM_OBJ; k++) begin
         if (idx == IW'(k)) begin
            cur_en = sh_en[k];
            cur_x0 = sh_x0[k];
            cur_y0 = sh_y0[k];
            cur_x1 = sh_x1[k];
            cur_y1 = sh_y1[k];
         end
      end
   end

`ifdef DRAW_SEQ_CLIP_EN
   localparam logic [N-1:0] XMAX = N'(SCREEN_W - 1);
   localparam logic [N-1:0] YMAX = N'(SCREEN_H - 1);

   function automatic logic [N-1:0] clamp(input logic [N-1:0] v, input logic [N-1:0] m);
      return (v > m) ? m : v;
   endfunction

   // Order each axis first, then clamp, so swapped corners still clip correctly.
   always_comb begin
      ld_x0 = clamp((cur_x0 > cur_x1) ? cur_x1 : cur_x0, XMAX);
      ld_x1 = clamp((cur_x0 > cur_x1) ? cur_x0 : cur_x1, XMAX);
      ld_y0 = clamp((cur_y0 > cur_y1) ? cur_y1 : cur_y0, YMAX);
      ld_y1 = clamp((cur_y0 > cur_y1) ? cur_y0 : cur_y1, YMAX);
   end
`else
   assign ld_x0 = cur_x0;
   assign ld_y0 = cur_y0;
   assign ld_x1 = cur_x1;
   assign ld_y1 = cur_y1;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         x0          <= '0;
         y0          <= '0;
         x1          <= '0;
         y1          <= '0;
         wr          <= 1'b0;
         clearScreen <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         overrun <= frame_start && (state != IDLE);
         case (state)
            IDLE: begin
               if (frame_start) begin
                  state       <= CLEAR;
                  idx         <= '0;
                  clearScreen <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            CLEAR: begin
               if (ready) begin
                  clearScreen <= 1'b0;
                  state       <= SCAN;
               end
            end
            SCAN: begin
               if (idx == LAST) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end else if (cur_en) begin
                  x0    <= ld_x0;
                  y0    <= ld_y0;
                  x1    <= ld_x1;
                  y1    <= ld_y1;
                  wr    <= 1'b1;
                  state <= EMIT;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            EMIT: begin
               if (ready) begin
                  wr    <= 1'b0;
                  idx   <= idx + IW'(1);
                  state <= SCAN;
               end
            end
            DONE: begin
               frame_done <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
